q1_sweep_ctrl: RTL

Self-checking sweep controller for the 4-input/2-output `q1` combinational block. On `start` it drives all 16 input combinations `{a,b,c,d}` into `q1` in ascending order, holding each for `HOLD_CYCLES` clocks. It samples `f`/`g` at the end of each hold window and compares them against parameterised expected truth tables. It reports error count, first failing vector and pass/fail, and serves as the on-chip (BIST-style) sequencer for `q1`.

---
 rtl/q1_sweep_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/q1_sweep_ctrl.sv
// BIST sequencer for the q1 block: sweeps all 16 {a,b,c,d} vectors, holds each
// HOLD_CYCLES clocks, and checks f/g against the expected truth tables.
module q1_sweep_ctrl #(
    parameter int          HOLD_CYCLES = 20,
    parameter logic [15:0] EXP_F       = 16'h0000,
    parameter logic [15:0] EXP_G       = 16'h0000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    input  logic       f_i,
    input  logic       g_i,
    output logic [3:0] vec_idx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [4:0] err_cnt_o,
    output logic [3:0] first_err_idx_o,
    output logic       first_err_vld_o
);

    localparam int            HW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    vec_idx_q, vec_idx_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [4:0]    err_cnt_q, err_cnt_d;
    logic [3:0]    first_err_idx_q, first_err_idx_d;
    logic          first_err_vld_q, first_err_vld_d;
    logic          pass_q, pass_d;

    logic last_hold, mismatch;

    assign last_hold = (hold_cnt_q == HOLD_LAST);
    assign mismatch  = (f_i != EXP_F[vec_idx_q]) | (g_i != EXP_G[vec_idx_q]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = DRIVE;
            DRIVE: begin
                if (abort_i)                              state_d = IDLE;
                else if (last_hold && vec_idx_q == 4'd15) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_o       = 1'b0;
        b_o       = 1'b0;
        c_o       = 1'b0;
        d_o       = 1'b0;
        vec_idx_o = 4'd0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            DRIVE: begin
                {a_o, b_o, c_o, d_o} = vec_idx_q;
                vec_idx_o            = vec_idx_q;
                busy_o               = 1'b1;
            end
            DONE: begin
                vec_idx_o = vec_idx_q;
                done_o    = 1'b1;
            end
            default: ;
        endcase
    end

    // Abort wins over a same-cycle compare, so the datapath only moves when it is low.
    always_comb begin
        vec_idx_d       = vec_idx_q;
        hold_cnt_d      = hold_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vld_d = first_err_vld_q;
        pass_d          = pass_q;
        if (state_q == IDLE && start_i) begin
            vec_idx_d       = 4'd0;
            hold_cnt_d      = '0;
            err_cnt_d       = 5'd0;
            first_err_idx_d = 4'd0;
            first_err_vld_d = 1'b0;
            pass_d          = 1'b0;
        end else if (state_q == DRIVE && !abort_i) begin
            if (last_hold) begin
                hold_cnt_d = '0;
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 5'd1;
                    if (!first_err_vld_q) begin
                        first_err_idx_d = vec_idx_q;
                        first_err_vld_d = 1'b1;
                    end
                end
                // pass is loaded on the final compare so it is already valid in DONE.
                if (vec_idx_q == 4'd15) pass_d = (err_cnt_d == 5'd0);
                else                    vec_idx_d = vec_idx_q + 4'd1;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vec_idx_q       <= 4'd0;
            hold_cnt_q      <= '0;
            err_cnt_q       <= 5'd0;
            first_err_idx_q <= 4'd0;
            first_err_vld_q <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            vec_idx_q       <= vec_idx_d;
            hold_cnt_q      <= hold_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vld_q <= first_err_vld_d;
            pass_q          <= pass_d;
        end
    end

    assign pass_o          = pass_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_idx_o = first_err_idx_q;
    assign first_err_vld_o = first_err_vld_q;

endmodule
